// File: rtl/led_controller.sv
// LED driver with DATA/MODE/PERIOD/DUTY registers, prescaled blink and 8-bit PWM gating.
// readData has 1 clk read latency; led pins have 1 clk from lit; no backpressure.
module led_controller #(
  parameter int NUM_LEDS   = 4,
  parameter int PRESCALE   = 1000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                writeEnable,
  input  logic                readEnable,
  input  logic [1:0]          addr,
  input  logic [7:0]          writeData,
  output logic [7:0]          readData,
  output logic [NUM_LEDS-1:0] led
);

  localparam int                PW      = $clog2(PRESCALE);
  localparam logic [PW-1:0]     PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [NUM_LEDS-1:0] DARK  = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [NUM_LEDS-1:0] r_data;
  logic [NUM_LEDS-1:0] r_mode;
  logic [7:0]          r_period;
  logic [7:0]          r_duty;
  logic [PW-1:0]       r_pre;
  logic [7:0]          r_blink;
  logic                r_phase;
  logic [7:0]          r_pwm;
  logic [7:0]          r_read_data;
  logic [NUM_LEDS-1:0] r_led;

  logic                w_tick;
  logic                w_per_wr;
  logic [7:0]          w_blink_nxt;
  logic                w_pwm_on;
  logic [NUM_LEDS-1:0] w_lit;
  logic [7:0]          w_rd_mux;

  assign w_tick      = (r_pre == PRE_MAX);
  assign w_per_wr    = writeEnable && (addr == 2'd2);
  assign w_blink_nxt = r_blink + 8'd1;
  assign w_pwm_on    = (r_duty == 8'hFF) || (r_pwm < r_duty);
  assign w_lit       = r_data & (~r_mode | {NUM_LEDS{r_phase}}) & {NUM_LEDS{w_pwm_on}};

  always_comb begin
    w_rd_mux = 8'h00;
    case (addr)
      2'd0:    w_rd_mux = 8'(r_data);
      2'd1:    w_rd_mux = 8'(r_mode);
      2'd2:    w_rd_mux = r_period;
      default: w_rd_mux = r_duty;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data   <= '0;
      r_mode   <= '0;
      r_period <= 8'h00;
      r_duty   <= 8'hFF;
    end else if (writeEnable) begin
      case (addr)
        2'd0:    r_data   <= writeData[NUM_LEDS-1:0];
        2'd1:    r_mode   <= writeData[NUM_LEDS-1:0];
        2'd2:    r_period <= writeData;
        default: r_duty   <= writeData;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
    end
  end

  // A PERIOD write restarts the blink in the lit half, overriding any tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_blink <= 8'h00;
      r_phase <= 1'b1;
    end else if (w_per_wr || (r_period == 8'h00)) begin
      r_blink <= 8'h00;
      r_phase <= 1'b1;
    end else if (w_tick) begin
      if (w_blink_nxt == r_period) begin
        r_blink <= 8'h00;
        r_phase <= ~r_phase;
      end else begin
        r_blink <= w_blink_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pwm       <= 8'h00;
      r_read_data <= 8'h00;
      r_led       <= DARK;
    end else begin
      r_pwm <= r_pwm + 8'd1;
      r_led <= w_lit ^ {NUM_LEDS{ACTIVE_LOW != 0}};
      if (readEnable) begin
        r_read_data <= w_rd_mux;
      end
    end
  end

  assign readData = r_read_data;
  assign led      = r_led;

endmodule

// File: tb/tb_led_controller.sv
// Bench for led_controller: register table, read scoreboard, blink, PWM and reset corner cases.
module tb_led_controller;

  logic       clk;
  logic       reset;
  logic       writeEnable;
  logic       readEnable;
  logic [1:0] addr;
  logic [7:0] writeData;
  logic [7:0] readData;
  logic [3:0] led;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic       fire;

  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] e;
  } vec_t;
  vec_t tbl[8];

  led_controller #(.NUM_LEDS(4), .PRESCALE(4), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .writeEnable(writeEnable), .readEnable(readEnable),
    .addr(addr), .writeData(writeData), .readData(readData), .led(led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Read results are checked as they appear, one edge after the strobe.
  always @(posedge clk) begin
    fire = reset && readEnable;
    #1;
    if (fire) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected: got %0h with empty scoreboard", readData);
      end else begin
        chk("readData", {24'h0, readData}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    writeEnable = 1'b1; readEnable = 1'b0; addr = a; writeData = d;
    @(negedge clk);
    writeEnable = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] e);
    @(negedge clk);
    readEnable = 1'b1; writeEnable = 1'b0; addr = a;
    exp_q.push_back(e);
    @(negedge clk);
    readEnable = 1'b0;
  endtask

  task automatic count_low(input int n, output int lows);
    lows = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (led[0] === 1'b0) lows++;
    end
  endtask

  initial begin
    int lows, ntr, last, bad_iv, hi_bad;
    logic prev, found;

    tbl[0] = '{2'd0, 8'hFF, 8'h0F};
    tbl[1] = '{2'd1, 8'hF3, 8'h03};
    tbl[2] = '{2'd2, 8'h00, 8'h00};
    tbl[3] = '{2'd3, 8'h01, 8'h01};
    tbl[4] = '{2'd0, 8'h5A, 8'h0A};
    tbl[5] = '{2'd1, 8'h00, 8'h00};
    tbl[6] = '{2'd2, 8'h7E, 8'h7E};
    tbl[7] = '{2'd3, 8'h80, 8'h80};

    reset = 1'b0; writeEnable = 1'b0; readEnable = 1'b0; addr = 2'd0; writeData = 8'h00;
    #23;
    chk("reset_led", {28'h0, led}, 32'hF);
    chk("reset_rd", {24'h0, readData}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    rd(2'd3, 8'hFF);
    rd(2'd0, 8'h00);

    wr(2'd0, 8'hA5);
    @(negedge clk);
    chk("static_led", {28'h0, led}, 32'hA);
    rd(2'd0, 8'h05);

    for (int i = 0; i < 8; i++) begin
      wr(tbl[i].a, tbl[i].d);
      rd(tbl[i].a, tbl[i].e);
    end
    wr(2'd3, 8'hFF); wr(2'd2, 8'h00); wr(2'd1, 8'h00);

    wr(2'd0, 8'h03);
    @(negedge clk);
    writeEnable = 1'b1; readEnable = 1'b1; addr = 2'd0; writeData = 8'h0C;
    exp_q.push_back(8'h03);
    @(negedge clk);
    writeEnable = 1'b0; readEnable = 1'b0;
    rd(2'd0, 8'h0C);

    wr(2'd0, 8'h01); wr(2'd1, 8'h01); wr(2'd2, 8'h03);
    prev = led[0]; last = -1; ntr = 0; bad_iv = 0; hi_bad = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (led[3:1] !== 3'b111) hi_bad++;
      if (led[0] !== prev) begin
        if (last >= 0 && (c - last) != 12) bad_iv++;
        last = c; ntr++; prev = led[0];
      end
    end
    chk("blink_enough_toggles", {31'h0, ntr >= 5}, 32'h1);
    chk("blink_interval_12", bad_iv, 0);
    chk("blink_upper_dark", hi_bad, 0);

    wr(2'd1, 8'h00); wr(2'd2, 8'h00); wr(2'd3, 8'd64);
    @(negedge clk); @(negedge clk);
    count_low(256, lows);
    chk("pwm_duty64_lows", lows, 64);
    wr(2'd3, 8'h00);
    @(negedge clk); @(negedge clk);
    count_low(256, lows);
    chk("pwm_duty0_lows", lows, 0);
    wr(2'd3, 8'hFF);
    @(negedge clk); @(negedge clk);
    count_low(256, lows);
    chk("pwm_duty255_lows", lows, 256);

    wr(2'd0, 8'h0F); wr(2'd1, 8'h01); wr(2'd2, 8'h03);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (led[0] === 1'b1) found = 1'b1;
    end
    chk("wait_off_phase", {31'h0, found}, 32'h1);
    chk("off_phase_led", {28'h0, led}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_led", {28'h0, led}, 32'hF);
    chk("async_reset_rd", {24'h0, readData}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    rd(2'd1, 8'h00);
    rd(2'd2, 8'h00);
    rd(2'd0, 8'h00);
    @(negedge clk);
    chk("post_reset_led", {28'h0, led}, 32'hF);

    @(negedge clk); @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_controller.md
LED_CONTROLLER -- requirements
Module: led_controller

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 4, meaning the number of LED channels (legal range 1..8).
REQ-002 SHALL have parameter PRESCALE, default 1000, meaning the clk cycles per blink tick (>=2).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1, meaning 1 drives a lit LED as 0.
REQ-004 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 SHALL have port writeEnable  input  1  register write strobe for this cycle.
REQ-007 SHALL have port readEnable  input  1  register read strobe for this cycle.
REQ-008 SHALL have port addr  input  2  register select: 0 DATA, 1 MODE, 2 PERIOD, 3 DUTY.
REQ-009 SHALL have port writeData  input  8  write payload.
REQ-010 SHALL have port readData  output  8  registered read result.
REQ-011 SHALL have port led  output  NUM_LEDS  LED pin drive, one bit per channel.

Function
REQ-012 SHALL write writeData into the addressed register on a clk edge with writeEnable=1.
REQ-013 SHALL store only bits [NUM_LEDS-1:0] of DATA and MODE; upper bits SHALL read as 0.
REQ-014 SHALL load readData with the addressed register on a clk edge with readEnable=1 (1-cycle latency), else hold readData.
REQ-015 SHALL return the pre-write value when read and write hit the same address in the same cycle.
REQ-016 SHALL run a prescaler counting 0..PRESCALE-1 and wrapping, asserting an internal tick for exactly one cycle at PRESCALE-1.
REQ-017 SHALL, on each tick with PERIOD!=0, increment a blink counter; when the incremented value reaches PERIOD, toggle the phase bit and clear the blink counter (phase half-period = PERIOD ticks).
REQ-018 SHALL hold phase=1 and blink counter=0 while PERIOD=0.
REQ-019 SHALL, on any write to PERIOD, clear the blink counter and set phase=1 (the write takes precedence over a coincident tick); the prescaler is unaffected.
REQ-020 SHALL run an 8-bit PWM counter incrementing every clk, wrapping 255->0.
REQ-021 SHALL compute pwm_on = (DUTY==255) or (pwm_cnt < DUTY); DUTY=0 SHALL keep all LEDs dark.
REQ-022 SHALL compute lit[i] = DATA[i] and (MODE[i] ? phase : 1) and pwm_on.
REQ-023 SHALL register led[i] = lit[i] xor ACTIVE_LOW, giving one cycle of latency from lit to pin.
REQ-024 SHALL make a register write visible on led no later than 2 clk edges after the write edge (subject to PWM/phase gating).

Reset
REQ-025 SHALL, while reset=0, asynchronously force DATA=0, MODE=0, PERIOD=0, DUTY=255, prescaler=0, blink counter=0, phase=1, pwm_cnt=0, readData=0.
REQ-026 SHALL, while reset=0, asynchronously force every led bit to the dark level (all 1s when ACTIVE_LOW=1, all 0s otherwise).
REQ-027 SHALL ignore writeEnable/readEnable while reset=0; reset asserted mid-blink SHALL abandon the phase with no residual state.
REQ-028 SHALL resume operation on the first clk edge after reset deasserts.

Verification
REQ-029 Bench SHALL check reset: reset=0 -> led=4'b1111, readData=0; release, read addr 3 -> readData=8'hFF two edges later.
REQ-030 Bench SHALL check static drive: write DATA=8'hA5, NUM_LEDS=4 -> led=4'b1010 within 2 edges; read DATA -> 8'h05.
REQ-031 Bench SHALL check blink (PRESCALE=4): DATA=1, MODE=1, PERIOD=3 -> led[0] toggles every 12 clk; led[3:1] stay 1.
REQ-032 Bench SHALL check PWM: DATA=1, DUTY=64 -> led[0] low for exactly 64 of every 256 clk; DUTY=0 -> led[0] constantly 1.
REQ-033 Bench SHALL check collision: simultaneous read+write addr 0 (old 8'h03, new 8'h0C) -> readData=8'h03, subsequent read 8'h0C.
REQ-034 Bench SHALL check reset mid-operation: assert reset during blink-off phase -> led=4'b1111 immediately, asynchronously (no clk edge), MODE reads 0 after release.
